bus_uart_tx: RTL and testbench

BUS_UART_TX -- requirements
Module: bus_uart_tx

---
 rtl/bus_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// Bus-mapped 8N1 UART transmitter with a small transmit FIFO.
// Register map: 0x0 STATUS (RO), 0x4 TXDATA (WO), 0x8 CTRL (RW).
module bus_uart_tx #(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    output logic        tx
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_TXDATA = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } stateT;

    logic [7:0]        fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              en;
    logic              overflow;

    stateT             state;
    logic [BAUD_W-1:0] baudCnt;
    logic [2:0]        bitIdx;
    logic [7:0]        shiftReg;

    logic              fifoFull;
    logic              fifoEmpty;
    logic              txWrite;
    logic              ctrlWrite;
    logic              bitDone;
    logic              pop;
    logic              push;
    logic [7:0]        headByte;
    logic [3:0]        countField;
    logic              unusedWData;

    assign fifoFull    = (count == CNT_FULL);
    assign fifoEmpty   = (count == '0);
    assign txWrite     = sel && we && (addr == ADDR_TXDATA);
    assign ctrlWrite   = sel && we && (addr == ADDR_CTRL);
    assign bitDone     = (baudCnt == BAUD_LAST);
    assign headByte    = fifoMem[rdPtr];
    assign countField  = 4'(count);
    assign unusedWData = &{1'b0, wData[31:8]};

    // A frame is loaded either from IDLE or straight out of the last STOP cycle,
    // which is what lets a push to a full FIFO land on the same edge as a pop.
    assign pop  = en && !fifoEmpty && ((state == IDLE) || ((state == STOP) && bitDone));
    assign push = txWrite && (!fifoFull || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            en       <= 1'b1;
        end else begin
            if (push) begin
                fifoMem[wrPtr] <= wData[7:0];
                wrPtr          <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (txWrite && !push) begin
                overflow <= 1'b1;
            end else if (ctrlWrite && wData[1]) begin
                overflow <= 1'b0;
            end
            if (ctrlWrite) begin
                en <= wData[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shiftReg <= headByte;
                        state    <= START;
                        tx       <= 1'b0;
                        baudCnt  <= '0;
                    end
                end
                START: begin
                    if (bitDone) begin
                        state    <= DATA;
                        tx       <= shiftReg[0];
                        shiftReg <= {1'b0, shiftReg[7:1]};
                        bitIdx   <= '0;
                        baudCnt  <= '0;
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bitDone) begin
                        baudCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bitIdx   <= bitIdx + 3'd1;
                            tx       <= shiftReg[0];
                            shiftReg <= {1'b0, shiftReg[7:1]};
                        end
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bitDone) begin
                        baudCnt <= '0;
                        if (pop) begin
                            shiftReg <= headByte;
                            state    <= START;
                            tx       <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rData = '0;
        if (sel && !we) begin
            case (addr)
                ADDR_STATUS: rData = {24'b0, countField, overflow, fifoEmpty, fifoFull, (state != IDLE)};
                ADDR_CTRL:   rData = {31'b0, en};
                default:     rData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx with BAUD_DIV=4, FIFO_DEPTH=8.
module tb_bus_uart_tx;

    localparam int BAUD  = 4;
    localparam int FRAME = 10 * BAUD;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wData;
    logic [31:0] rData;
    logic        tx;

    int checks = 0;
    int errors = 0;
    logic [7:0] expBytes [16];

    typedef struct {
        logic        sel;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wData;
        logic [31:0] expR;
        logic        expTx;
    } vecT;

    vecT vecs [12];

    bus_uart_tx #(.BAUD_DIV(4), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wData (wData),
        .rData (rData),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wData = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; addr = 4'h0; wData = '0;
    endtask

    task automatic readStatusMode();
        sel = 1'b1; we = 1'b0; addr = 4'h0; wData = '0;
    endtask

    // k counts edges since the edge that made the first byte visible to the FSM.
    task automatic checkFrames(input int k0, input int n, input bit chkBusy);
        int f;
        int b;
        logic expBit;
        for (int k = k0 + 1; k <= n * FRAME; k++) begin
            @(negedge clk);
            f = (k - 1) / FRAME;
            b = ((k - 1) % FRAME) / BAUD;
            if (b == 0) expBit = 1'b0;
            else if (b == 9) expBit = 1'b1;
            else expBit = expBytes[f][b - 1];
            checkBit($sformatf("tx frame%0d bit%0d k%0d", f, b, k), tx, expBit);
            if (chkBusy) checkBit($sformatf("busy k%0d", k), rData[0], 1'b1);
        end
        @(negedge clk);
        checkBit("tx idle after frames", tx, 1'b1);
        if (chkBusy) checkBit("busy clear after frames", rData[0], 1'b0);
    endtask

    task automatic waitIdle(input int maxCycles);
        readStatusMode();
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (rData[0] == 1'b0) break;
        end
        checkBit("idle reached within bound", rData[0], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 4'h0; wData = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkBit("tx after reset", tx, 1'b1);

        // Decode and register table; each vector is held across one posedge.
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 32'h0,  32'h0000_0004, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 4'h8, 32'h0,  32'h0000_0001, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 4'h4, 32'h0,  32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 4'hC, 32'h0,  32'h0000_0000, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 32'h0,  32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 4'h4, 32'h33, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 4'hC, 32'hFF, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 4'h8, 32'h1,  32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 4'h0, 32'h0,  32'h0000_0004, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'h4, 32'h5A, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h0,  32'h0000_0010, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 4'h0, 32'h0,  32'h0000_0005, 1'b0};
        for (int v = 0; v < 12; v++) begin
            sel = vecs[v].sel; we = vecs[v].we; addr = vecs[v].addr; wData = vecs[v].wData;
            #1;
            check($sformatf("vec%0d rData", v), rData, vecs[v].expR);
            checkBit($sformatf("vec%0d tx", v), tx, vecs[v].expTx);
            @(negedge clk);
        end
        sel = 1'b0; we = 1'b0; addr = 4'h0; wData = '0;
        waitIdle(100);

        // Single byte 0xA5 from idle
        expBytes[0] = 8'hA5;
        busWrite(4'h4, 32'hA5);
        readStatusMode();
        #1;
        check("single pushed not popped", rData, 32'h0000_0010);
        checkFrames(0, 1, 1'b1);

        // Back-to-back frames with no idle gap
        expBytes[0] = 8'h55;
        expBytes[1] = 8'h0F;
        busWrite(4'h4, 32'h55);
        busWrite(4'h4, 32'h0F);
        readStatusMode();
        checkFrames(1, 2, 1'b1);

        // Overflow with EN=0, then release
        busWrite(4'h8, 32'h0);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expBytes[i] = 8'(8'h10 + i * 8'h13);
            busWrite(4'h4, 32'(8'h10 + i * 8'h13));
        end
        sel = 1'b1; we = 1'b0; addr = 4'h8;
        #1;
        check("ctrl EN cleared", rData, 32'h0);
        readStatusMode();
        #1;
        check("overflow status", rData, 32'h0000_008A);
        repeat (5) @(negedge clk);
        check("overflow status held", rData, 32'h0000_008A);
        checkBit("tx idle while disabled", tx, 1'b1);
        busWrite(4'h8, 32'h3);
        readStatusMode();
        #1;
        check("overflow cleared", rData, 32'h0000_0082);
        checkFrames(0, 8, 1'b1);
        #1;
        check("status after drain", rData, 32'h0000_0004);

        // Full FIFO with a push on the same edge as a pop
        for (int i = 0; i < 10; i++) expBytes[i] = 8'(i * 29 + 7);
        busWrite(4'h4, {24'b0, expBytes[0]});
        fork
            checkFrames(0, 10, 1'b0);
            begin
                for (int i = 1; i < 9; i++) busWrite(4'h4, {24'b0, expBytes[i]});
                readStatusMode();
                #1;
                check("full before pop", rData, 32'h0000_0083);
                repeat (32) @(negedge clk);
                busWrite(4'h4, {24'b0, expBytes[9]});
                readStatusMode();
                #1;
                check("push on pop accepted", rData, 32'h0000_0083);
            end
        join
        readStatusMode();
        #1;
        check("status after full-with-pop", rData, 32'h0000_0004);

        // Reset during DATA bit 3, with a simultaneous TXDATA write
        busWrite(4'h4, 32'hF0);
        busWrite(4'h4, 32'h33);
        repeat (16) @(negedge clk);
        checkBit("tx data bit3 before reset", tx, 1'b0);
        reset = 1'b1; sel = 1'b1; we = 1'b1; addr = 4'h4; wData = 32'h77;
        @(negedge clk);
        reset = 1'b0;
        readStatusMode();
        #1;
        checkBit("tx after mid-frame reset", tx, 1'b1);
        check("status after mid-frame reset", rData, 32'h0000_0004);
        sel = 1'b1; we = 1'b0; addr = 4'h8;
        #1;
        check("ctrl EN after reset", rData, 32'h0000_0001);
        readStatusMode();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checkBit($sformatf("tx stays idle c%0d", i), tx, 1'b1);
        end
        check("status stays idle", rData, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
